// File: rtl/rst_seq_wdog.sv
// rtl/rst_seq_wdog.sv - reset sequencer with DDR calibration watchdog and staggered channel release
//
// Holds the DDR controller in reset, supervises calibration with a bounded
// number of attempts, then releases NUM_CH downstream reset domains in index
// order, one every STAGE_DLY cycles.
//
// Ports:
//   sys_clk       single clock
//   sys_rst_n     asynchronous active-low reset
//   pll_locked    async PLL lock, synchronised to lock_s
//   calc_done     async DDR calibration done, synchronised to done_s
//   soft_rst_req  sys_clk-synchronous single-cycle request to re-run the sequence
//   rst_ddr_n     DDR controller reset, active-low
//   rst_ch_n      downstream resets, active-low, released in index order
//   seq_ready     high while the sequence is complete (RUN)
//   calib_fail    high once all calibration attempts are exhausted (FAIL)
//   retry_cnt     failed calibration attempts in the current sequence
module rst_seq_wdog #(
  parameter int NUM_CH      = 3,
  parameter int STAGE_DLY   = 16,
  parameter int DDR_RST_CYC = 4096,
  parameter int WDOG_WIDTH  = 26,
  parameter int MAX_RETRY   = 3,
  parameter int SYNC_STAGES = 2,
  localparam int RW         = $clog2(MAX_RETRY + 1)
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              pll_locked,
  input  logic              calc_done,
  input  logic              soft_rst_req,
  output logic              rst_ddr_n,
  output logic [NUM_CH-1:0] rst_ch_n,
  output logic              seq_ready,
  output logic              calib_fail,
  output logic [RW-1:0]     retry_cnt
);

  localparam int DW = $clog2(DDR_RST_CYC + 1);
  localparam int SW = $clog2(STAGE_DLY + 1);

  localparam logic [DW-1:0] DDR_LAST   = DW'(DDR_RST_CYC - 1);
  localparam logic [SW-1:0] STG_LAST   = SW'(STAGE_DLY - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK,
    ST_DDR_RST,
    ST_CALIB,
    ST_RELEASE,
    ST_RUN,
    ST_FAIL
  } state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  lock_sync;
  logic [SYNC_STAGES-1:0]  done_sync;
  logic                    lock_s;
  logic                    done_s;
  logic [DW-1:0]           ddr_cnt;
  logic [WDOG_WIDTH-1:0]   wdog_cnt;
  logic [SW-1:0]           stage_cnt;
  logic [NUM_CH-1:0]       ch_next;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lock_sync <= '0;
      done_sync <= '0;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked};
      done_sync <= {done_sync[SYNC_STAGES-2:0], calc_done};
    end
  end

  assign lock_s = lock_sync[SYNC_STAGES-1];
  assign done_s = done_sync[SYNC_STAGES-1];

  // Channels release strictly in index order, so the released set is always
  // a run of ones from bit 0; shifting in a one releases the next channel.
  assign ch_next = (rst_ch_n << 1) | NUM_CH'(1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_WAIT_LOCK;
      rst_ddr_n  <= 1'b0;
      rst_ch_n   <= '0;
      seq_ready  <= 1'b0;
      calib_fail <= 1'b0;
      retry_cnt  <= '0;
      ddr_cnt    <= '0;
      wdog_cnt   <= '0;
      stage_cnt  <= '0;
    end else if (state != ST_WAIT_LOCK && !lock_s) begin
      // Lock loss outranks a coincident soft request.
      state      <= ST_WAIT_LOCK;
      rst_ddr_n  <= 1'b0;
      rst_ch_n   <= '0;
      seq_ready  <= 1'b0;
      calib_fail <= 1'b0;
      retry_cnt  <= '0;
    end else if (state != ST_WAIT_LOCK && soft_rst_req) begin
      state      <= ST_DDR_RST;
      rst_ddr_n  <= 1'b0;
      rst_ch_n   <= '0;
      seq_ready  <= 1'b0;
      calib_fail <= 1'b0;
      retry_cnt  <= '0;
      ddr_cnt    <= '0;
    end else begin
      case (state)
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state   <= ST_DDR_RST;
            ddr_cnt <= '0;
          end
        end

        ST_DDR_RST: begin
          if (ddr_cnt == DDR_LAST) begin
            state     <= ST_CALIB;
            rst_ddr_n <= 1'b1;
            wdog_cnt  <= '0;
          end else begin
            ddr_cnt <= ddr_cnt + DW'(1);
          end
        end

        ST_CALIB: begin
          // done_s is tested first so a done arriving on the expiry cycle wins.
          if (done_s) begin
            state     <= ST_RELEASE;
            stage_cnt <= '0;
          end else if (&wdog_cnt) begin
            rst_ddr_n <= 1'b0;
            ddr_cnt   <= '0;
            if (retry_cnt != RETRY_MAX) begin
              retry_cnt <= retry_cnt + RW'(1);
            end
            if (retry_cnt == RETRY_LAST) begin
              state      <= ST_FAIL;
              calib_fail <= 1'b1;
            end else begin
              state <= ST_DDR_RST;
            end
          end else begin
            wdog_cnt <= wdog_cnt + WDOG_WIDTH'(1);
          end
        end

        ST_RELEASE: begin
          if (!done_s) begin
            state     <= ST_DDR_RST;
            rst_ddr_n <= 1'b0;
            rst_ch_n  <= '0;
            ddr_cnt   <= '0;
          end else if (stage_cnt == STG_LAST) begin
            stage_cnt <= '0;
            rst_ch_n  <= ch_next;
            // seq_ready follows one cycle later, from the RUN state itself.
            if (&ch_next) begin
              state <= ST_RUN;
            end
          end else begin
            stage_cnt <= stage_cnt + SW'(1);
          end
        end

        ST_RUN: begin
          if (!done_s) begin
            state     <= ST_DDR_RST;
            rst_ddr_n <= 1'b0;
            rst_ch_n  <= '0;
            seq_ready <= 1'b0;
            retry_cnt <= '0;
            ddr_cnt   <= '0;
          end else begin
            seq_ready <= 1'b1;
          end
        end

        ST_FAIL: begin
          // Held until lock loss, soft request or reset.
        end

        default: begin
          state <= ST_WAIT_LOCK;
        end
      endcase
    end
  end

endmodule

// File: doc/rst_seq_wdog.md
# rst_seq_wdog

Parametrised reset sequencer and DDR calibration watchdog, successor to the fixed single-output clock/reset watchdog. Sits after the PLL/clock buffers in the `sys_clk` domain. It holds the DDR controller in reset, supervises calibration with a bounded retry count, then releases `NUM_CH` downstream reset domains in a fixed order with a programmable stagger. Lock loss, calibration loss and soft-reset requests re-run the sequence; exhausted retries latch a failure flag.

## Interface
- `NUM_CH`, 3: number of downstream reset outputs, released in index order (min 1).
- `STAGE_DLY`, 16: cycles between successive channel releases (min 1).
- `DDR_RST_CYC`, 4096: cycles `rst_ddr_n` is held low per attempt (min 1).
- `WDOG_WIDTH`, 26: calibration timeout is 2^`WDOG_WIDTH` cycles.
- `MAX_RETRY`, 3: calibration attempts before FAIL (min 1).
- `SYNC_STAGES`, 2: synchroniser depth for the async inputs (min 2).

Ports:
- `sys_clk`  in  1  single clock.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `pll_locked`  in  1  async; synchronised internally to `lock_s`.
- `calc_done`  in  1  async DDR calibration done; synchronised internally to `done_s`.
- `soft_rst_req`  in  1  sys_clk-synchronous single-cycle request to re-run the sequence.
- `rst_ddr_n`  out  1  DDR controller reset, active-low.
- `rst_ch_n`  out  `NUM_CH`  downstream resets, active-low.
- `seq_ready`  out  1  high in RUN only.
- `calib_fail`  out  1  high in FAIL only.
- `retry_cnt`  out  clog2(`MAX_RETRY`+1)  failed attempts in the current sequence.

## Operation
- FSM states: WAIT_LOCK, DDR_RST, CALIB, RELEASE, RUN, FAIL. All outputs are registered.
- Reset (`sys_rst_n`=0): state WAIT_LOCK; `rst_ddr_n`=0; `rst_ch_n`=all 0; `seq_ready`=0; `calib_fail`=0; `retry_cnt`=0; all counters 0; synchronisers cleared to 0.
- WAIT_LOCK: all resets asserted. On `lock_s`=1, go to DDR_RST.
- DDR_RST: `rst_ddr_n`=0 and channels asserted. After `DDR_RST_CYC` cycles, go to CALIB.
- CALIB: `rst_ddr_n`=1 and the watchdog counter increments every cycle.
  - `done_s`=1: go to RELEASE.
  - Counter reaches all-ones with `done_s`=0: `retry_cnt` increments. If the new value equals `MAX_RETRY`, go to FAIL; otherwise go to DDR_RST.
  - Watchdog counter clears on every CALIB entry.
- RELEASE: a stage counter counts 0..`STAGE_DLY`-1. At each wrap, the next channel index is deasserted (index 0 first). After channel `NUM_CH`-1 is released, go to RUN.
  - If `done_s` drops, go to DDR_RST and reassert all released channels.
- RUN: `seq_ready`=1. If `done_s` drops, reassert all channels, clear `retry_cnt`, go to DDR_RST.
- FAIL: `rst_ddr_n`=0, channels asserted, `calib_fail`=1. Exit only via lock loss, `soft_rst_req` or `sys_rst_n`.
- Global events, highest priority first:
  - `lock_s`=0 in any state except WAIT_LOCK: go to WAIT_LOCK, assert all resets, clear `retry_cnt` and `calib_fail`.
  - `soft_rst_req`=1 in any state except WAIT_LOCK: go to DDR_RST, assert all resets, clear `retry_cnt` and `calib_fail`, restart counters.
- A simultaneous lock loss and `soft_rst_req` resolves to WAIT_LOCK.
- A `done_s` rise on the same cycle as watchdog expiry counts as done (no retry).

## Timing
- Input latency: `SYNC_STAGES` cycles from an async input edge to `lock_s`/`done_s`.
- FSM response: one further cycle to the state and output change.
- `rst_ddr_n` is low for exactly `DDR_RST_CYC` consecutive cycles per attempt. It rises on the CALIB entry edge.
- Timeout: a retry fires exactly 2^`WDOG_WIDTH` cycles after CALIB entry.
- Channel release: `rst_ch_n[i]` rises `STAGE_DLY`*(i+1) cycles after RELEASE entry.
- `seq_ready` rises exactly 1 cycle after `rst_ch_n[NUM_CH-1]`.
- Reassertion on a global event or `done_s` loss: all resets go low on the cycle after detection, with no staggering.
- `retry_cnt` saturates at `MAX_RETRY` and never wraps.

## Test plan
Bench parameters: `NUM_CH`=3, `STAGE_DLY`=4, `DDR_RST_CYC`=8, `WDOG_WIDTH`=6, `MAX_RETRY`=2.
- Nominal: `pll_locked` rises, and `calc_done` rises 20 cycles into CALIB -> `rst_ddr_n` low for 8 cycles; `rst_ch_n` goes 001, 011, 111 at +4, +8, +12 from RELEASE entry; `seq_ready` rises at +13; `retry_cnt`=0.
- Single timeout: `calc_done` stays 0 through the first attempt and rises during the second -> `retry_cnt`=1 after 64 cycles; DDR reset pulse repeats for 8 cycles; sequence completes with `seq_ready`=1.
- Retry exhaustion: `calc_done` held 0 -> after two 64-cycle timeouts, `calib_fail`=1, `retry_cnt`=2, `rst_ddr_n`=0. A `soft_rst_req` pulse then gives `calib_fail`=0, `retry_cnt`=0, and state DDR_RST.
- Lock loss in RUN: drop `pll_locked` -> all resets low and `seq_ready`=0 within `SYNC_STAGES`+1 cycles; on re-lock, the full sequence replays.
- Calibration loss mid-RELEASE (after channel 0 released): drop `calc_done` -> `rst_ch_n`=000 and `rst_ddr_n`=0 within 3 cycles; DDR_RST replays.
- Async reset mid-CALIB: assert `sys_rst_n` -> all outputs return to reset values immediately, without waiting for a clock edge.
